// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, defaults and write-port arbitration for regfile_mp
package regfile_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int MAXWR = 32;
  typedef struct packed {
    logic       hit;
    logic [4:0] port;
  } wsel_t;
  // Later ports overwrite earlier ones, so the highest matching index wins.
  function automatic wsel_t win_port(input logic [MAXWR-1:0] hit);
    win_port = '0;
    for (int k = 0; k < MAXWR; k++)
      if (hit[k]) win_port = '{hit: 1'b1, port: 5'(k)};
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with alloc/writeback/flush and busy lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREG-1:0] wr_hit,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  input  logic            flush,
  output logic [NRD-1:0]  rd_busy
);
  logic [NREG-1:0] pend, pend_nx;
  always_comb begin
    pend_nx = pend;
    if (en)
      for (int r = 1; r < NREG; r++)
        pend_nx[r] = flush ? 1'b0 :
                     (alloc_valid && alloc_rd == AW'(r)) ? 1'b1 :
                     wr_hit[r] ? 1'b0 : pend[r];
    pend_nx[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend <= '0;
    else pend <= pend_nx;
  // A same-cycle writeback hides the pending bit so the consumer can take bypassed data.
  for (genvar p = 0; p < NRD; p++) begin : g_busy
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_busy[p] = en && pend[a] && !wr_hit[a];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, pending scoreboard and post-reset clear
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NWR-1:0]      wb_wen,
  input  logic [NWR*AW-1:0]   wb_rd,
  input  logic [NWR*XLEN-1:0] wb_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_rd,
  input  logic                flush
);
  state_t state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] wv [NREG];
  wsel_t wsel [NREG];
  logic [NREG-1:0] wr_hit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  // NREG is a power of two, so an all-ones index is the last entry.
  always_comb begin
    state_nx = (state == CLEAR && &idx) ? READY : state;
    idx_nx   = (state == CLEAR) ? idx + 1'b1 : idx;
  end
  assign ready = state == READY;
  for (genvar r = 0; r < NREG; r++) begin : g_sel
    logic [MAXWR-1:0] hit;
    logic [XLEN-1:0] d;
    wsel_t s;
    always_comb begin
      hit = '0;
      for (int k = 0; k < NWR; k++)
        hit[k] = wb_wen[k] && wb_rd[k*AW +: AW] == AW'(r);
    end
    assign s = win_port(hit);
    always_comb begin
      d = '0;
      for (int k = 0; k < NWR; k++)
        if (s.port == 5'(k)) d = wb_data[k*XLEN +: XLEN];
    end
    assign wsel[r]   = s;
    assign wv[r]     = d;
    assign wr_hit[r] = s.hit && ready && r != 0;
  end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[idx] <= '0;
    else
      for (int r = 1; r < NREG; r++)
        if (wr_hit[r]) mem[r] <= wv[r];
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_data[p*XLEN +: XLEN] = (!ready || a == '0) ? '0 :
                                     wsel[a].hit ? wv[a] : mem[a];
  end
  regfile_scoreboard #(.NREG(NREG), .NRD(NRD), .AW(AW)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .en         (ready),
    .wr_hit     (wr_hit),
    .rd_addr    (rd_addr),
    .alloc_valid(alloc_valid),
    .alloc_rd   (alloc_rd),
    .flush      (flush),
    .rd_busy    (rd_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven scoreboard bench for regfile_mp (NREG=32, NRD=2, NWR=2)
module tb_regfile_mp;
  localparam int XLEN = 64, NREG = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0, rst = 1'b0;
  logic ready;
  logic [NWR-1:0] wb_wen;
  logic [NWR*AW-1:0] wb_rd;
  logic [NWR*XLEN-1:0] wb_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic alloc_valid, flush;
  logic [AW-1:0] alloc_rd;
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .ready(ready), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .flush(flush)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] wen;
    logic [4:0] w0, w1;
    logic [63:0] d0, d1;
    logic [4:0] a0, a1;
    logic av;
    logic [4:0] ar;
    logic fl;
    logic [63:0] e0, e1;
    logic [1:0] eb;
  } vec_t;
  typedef struct {
    logic [63:0] e0, e1;
    logic [1:0] eb;
  } exp_t;
  vec_t tv[$];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t v(input logic [1:0] wen, input logic [4:0] w0, input logic [63:0] d0,
                             input logic [4:0] w1, input logic [63:0] d1,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic av, input logic [4:0] ar, input logic fl,
                             input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] eb);
    v = '{wen, w0, w1, d0, d1, a0, a1, av, ar, fl, e0, e1, eb};
  endfunction
  task automatic drive(input vec_t t);
    wb_wen = t.wen; wb_rd = {t.w1, t.w0}; wb_data = {t.d1, t.d0};
    rd_addr = {t.a1, t.a0}; alloc_valid = t.av; alloc_rd = t.ar; flush = t.fl;
  endtask
  task automatic idle();
    wb_wen = '0; wb_rd = '0; wb_data = '0; alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
  endtask
  task automatic wait_ready(input string nm);
    for (int i = 0; i < NREG; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_ready_e%0d", nm, i + 1), 64'(ready), 64'(i == NREG - 1));
      if (i < NREG - 1) begin
        chk($sformatf("%s_d0_e%0d", nm, i + 1), rd_data[63:0], 64'h0);
        chk($sformatf("%s_busy_e%0d", nm, i + 1), 64'(rd_busy), 64'h0);
      end
    end
  endtask
  initial begin
    localparam logic [63:0] DB = 64'hDEADBEEF;
    exp_t e;
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    // writes and allocs issued during the clear must be ignored
    wb_wen = 2'b01; wb_rd = {5'd0, 5'd5}; wb_data = {64'h0, 64'hFF};
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    @(negedge clk) rst = 1'b1;
    wait_ready("clr1");
    idle(); #1;
    chk("post_clr_x5", rd_data[63:0], 64'h0);
    chk("post_clr_busy", 64'(rd_busy), 64'h0);
    tv.push_back(v(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 5, DB, 0, 0, 5, 0, 0, 0, 0, DB, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, DB, 0, 0));
    tv.push_back(v(1, 0, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, DB, 0));
    tv.push_back(v(3, 7, 1, 7, 2, 7, 5, 0, 0, 0, 2, DB, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 2, 2, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 3, 7, 1, 3, 0, 0, 2, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b01));
    tv.push_back(v(1, 3, 9, 0, 0, 3, 0, 0, 0, 0, 9, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 9, 0, 0));
    tv.push_back(v(1, 3, 10, 0, 0, 3, 0, 1, 3, 0, 10, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 10, 0, 2'b01));
    tv.push_back(v(0, 0, 0, 0, 0, 3, 1, 1, 1, 0, 10, 0, 2'b01));
    tv.push_back(v(0, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 2'b01));
    tv.push_back(v(0, 0, 0, 0, 0, 2, 4, 1, 4, 0, 0, 0, 2'b01));
    tv.push_back(v(0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 2'b11));
    tv.push_back(v(0, 0, 0, 0, 0, 2, 4, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 10, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 3, 4, 1, 4, 0, 10, 0, 0));
    tv.push_back(v(2, 0, 0, 4, 6, 3, 4, 0, 0, 1, 10, 6, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 4, 4, 0, 0, 0, 6, 6, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 4, 1, 6, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 6, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 6, 0));
    tv.push_back(v(3, 8, 64'hAA, 9, 64'hBB, 8, 9, 0, 0, 0, 64'hAA, 64'hBB, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 9, 8, 0, 0, 0, 64'hBB, 64'hAA, 0));
    tv.push_back(v(1, 7, 5, 7, 6, 7, 7, 0, 0, 0, 5, 5, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 7, 3, 0, 0, 0, 5, 10, 0));
    foreach (tv[i]) begin
      @(posedge clk); #1;
      drive(tv[i]);
      sb.push_back('{tv[i].e0, tv[i].e1, tv[i].eb});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_d0", i), rd_data[63:0], e.e0);
      chk($sformatf("v%0d_d1", i), rd_data[127:64], e.e1);
      chk($sformatf("v%0d_busy", i), 64'(rd_busy), 64'(e.eb));
    end
    @(posedge clk); #1;
    idle();
    alloc_valid = 1'b1; alloc_rd = 5'd10; rd_addr = {5'd5, 5'd10};
    @(posedge clk); #1;
    idle();
    chk("pre_rst_busy", 64'(rd_busy), 64'b01);
    chk("pre_rst_x5", rd_data[127:64], DB);
    rst = 1'b0; #1;
    chk("async_rst_ready", 64'(ready), 64'h0);
    chk("async_rst_busy", 64'(rd_busy), 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("midclr_ready", 64'(ready), 64'h0);
    rst = 1'b1;
    wait_ready("clr2");
    chk("clr2_busy", 64'(rd_busy), 64'h0);
    chk("clr2_x10", rd_data[63:0], 64'h0);
    chk("clr2_x5", rd_data[127:64], 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with same-cycle write-to-read bypass, a per-register pending (scoreboard) bit, and a sequential post-reset clear engine. It replaces the single-write, two-read register file between decode and writeback in the cache-CPU pipeline. It also supports dual-issue and multi-writeback configurations and gives decode a hazard indication.

## Interface
- XLEN, 64, data width per register
- NREG, 32, register count; power of two, at least 2; entry 0 is hardwired zero
- NRD, 2, number of read ports
- NWR, 1, number of write ports; where several ports write one register, the highest port index wins
- AW, $clog2(NREG), register address width (derived)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- ready  out  1  low while the clear engine runs; reset value 0
- wb_wen  in  NWR  per-port write enable
- wb_rd  in  NWR*AW  per-port destination; port k occupies bits [k*AW +: AW]
- wb_data  in  NWR*XLEN  per-port write data
- rd_addr  in  NRD*AW  per-port read address
- rd_data  out  NRD*XLEN  per-port read data; combinational
- rd_busy  out  NRD  per-port pending flag for the addressed register; combinational
- alloc_valid  in  1  marks the register at alloc_rd pending (issue of a producer)
- alloc_rd  in  AW  register to mark pending
- flush  in  1  clears all pending bits (pipeline squash)

## Operation
- States: CLEAR and READY.
  - rst low forces CLEAR asynchronously, sets clear index to 0 and clears all pending bits.
  - In CLEAR, each cycle writes 0 to entry idx, then increments idx.
  - After the cycle that writes entry NREG-1, the block enters READY.
  - READY persists until the next reset.
- Behaviour in CLEAR:
  - ready is 0.
  - wb_wen, alloc_valid and flush are ignored.
  - rd_data is 0 and rd_busy is 0 on all ports.
- Writes, in READY:
  - On a clock edge, every port with wb_wen=1 and wb_rd≠0 writes wb_data to its entry.
  - Where several ports target the same register, the highest port index wins.
- Reads:
  - Address 0 returns 0.
  - Otherwise, a read returns the winning same-cycle write data if any enabled write port targets that address (bypass). If none does, it returns the array contents.
- Pending bits, in READY, per register r≠0, in priority order:
  1. flush: the bit becomes 0.
  2. alloc_valid with alloc_rd=r: the bit becomes 1. Alloc beats a simultaneous writeback to r, because the new producer supersedes the old one.
  3. An enabled writeback to r: the bit becomes 0.
  4. Otherwise the bit holds.
  - Register 0 is never pending. alloc_rd=0 is a no-op.
- rd_busy[p] = pending[rd_addr[p]] AND NOT (a same-cycle enabled write to rd_addr[p]). A consumer may therefore take bypassed data in the writeback cycle.
- flush does not affect array contents or writes issued in the same cycle.

## Timing
- Reset values:
  - ready=0.
  - All pending bits 0.
  - Clear index 0.
  - Array contents undefined until the clear completes.
- Clear latency: ready rises exactly NREG rising edges after rst is released. It is observed high after edge NREG.
- Read latency is 0 cycles (combinational), including the bypass path.
- A write or alloc sampled at edge N is visible in the array or pending bit after edge N.
- Reset mid-clear or mid-operation restarts the clear from index 0 and drops all pending state.
- Out-of-range addresses cannot occur because NREG is a power of two.

## Structure
- A shared package regfile_pkg holds:
  - the state enum (CLEAR, READY);
  - the default XLEN and NREG constants;
  - a function that selects the winning write port for an address. Bypass and write logic share this function.
- One natural sub-module, regfile_scoreboard, holds the NREG pending bits with the alloc, writeback and flush logic and the rd_busy lookup. The array, the bypass and the clear FSM stay in regfile_mp.

## Test plan
- Reset and clear, NREG=32: release rst → ready=0 for 32 cycles and 1 after the 32nd edge; reading any address returns 0.
- Write/bypass, NWR=1: wb x5=64'hDEADBEEF with rd_addr[0]=5 in the same cycle → rd_data[0]=64'hDEADBEEF that cycle and the next. A write to x0 → reads of x0 return 0.
- Port conflict, NWR=2: port0 writes x7=1 and port1 writes x7=2 in the same cycle → bypass gives 2 and the array holds 2 afterwards.
- Scoreboard: alloc x3 → rd_busy=1 on x3. A later wb x3=9 → rd_busy=0 in the wb cycle and rd_data=9. Alloc x3 and wb x3 in the same cycle → x3 remains pending.
- flush: alloc x1, x2 and x4, then flush → all rd_busy=0 the next cycle. flush together with wb x4=6 → x4 reads 6.
- Reset mid-clear: pulse rst low at cycle 10 of the clear → all state is dropped and ready rises 32 edges after the second release.
